// File: rtl/bus_rr_arbiter_pkg.sv
// bus_rr_arbiter_pkg: shared bus header with owner codes, arbiter states and polarity constants
package bus_rr_arbiter_pkg;
  localparam int BusOwnerBus = 2;
  localparam logic [BusOwnerBus-1:0] BUS_OWNER_MASTER_0 = 2'd0;
  localparam logic [BusOwnerBus-1:0] BUS_OWNER_MASTER_1 = 2'd1;
  localparam logic [BusOwnerBus-1:0] BUS_OWNER_MASTER_2 = 2'd2;
  localparam logic [BusOwnerBus-1:0] BUS_OWNER_MASTER_3 = 2'd3;
  localparam logic ENABLE_ = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  typedef enum logic {
    BUS_ARB_STATE_ARB  = 1'b0,
    BUS_ARB_STATE_BUSY = 1'b1
  } arb_state_t;
  function automatic logic [3:0] grant_of(logic [BusOwnerBus-1:0] o);
    return o == BUS_OWNER_MASTER_3 ? 4'b0111 :
           o == BUS_OWNER_MASTER_2 ? 4'b1011 :
           o == BUS_OWNER_MASTER_1 ? 4'b1101 : 4'b1110;
  endfunction
endpackage

// File: rtl/bus_rr_pick.sv
// bus_rr_pick: combinational round-robin picker searching upward from owner+1 with wrap
module bus_rr_pick
  import bus_rr_arbiter_pkg::*;
(
  input  logic [BusOwnerBus-1:0] owner,
  input  logic [3:0]             req,
  output logic [BusOwnerBus-1:0] nxt,
  output logic                   vld
);
  always_comb begin
    nxt = owner;
    vld = 1'b0;
    for (int k = 3; k >= 1; k--) begin
      if (req[owner + BusOwnerBus'(k)]) begin
        nxt = owner + BusOwnerBus'(k);
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: four-master round-robin bus arbiter; optional watchdog under BUS_ARB_TIMEOUT_EN
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  input  logic       m_as_,
  input  logic       s_rdy_,
  output logic       m_rdy_,
  output logic       bus_err,
  output logic [1:0] err_owner,
  input  logic       err_clr
);
  arb_state_t state, state_nxt;
  logic [BusOwnerBus-1:0] owner, owner_nxt, pick;
  logic [3:0] req_n, grnt;
  logic pick_vld, fire;
  assign req_n = {m3_req_, m2_req_, m1_req_, m0_req_};
  bus_rr_pick u_pick (
    .owner(owner),
    .req  (~req_n),
    .nxt  (pick),
    .vld  (pick_vld)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BUS_ARB_STATE_ARB;
      owner <= BUS_OWNER_MASTER_0;
      grnt  <= grant_of(BUS_OWNER_MASTER_0);
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      grnt  <= grant_of(owner_nxt);
    end
  end
  // A strobe in ARB takes priority over a release in the same cycle
  always_comb begin
    state_nxt = state == BUS_ARB_STATE_ARB
      ? ((m_as_ == ENABLE_ && s_rdy_ == DISABLE_) ? BUS_ARB_STATE_BUSY : BUS_ARB_STATE_ARB)
      : ((s_rdy_ == ENABLE_ || fire) ? BUS_ARB_STATE_ARB : BUS_ARB_STATE_BUSY);
    owner_nxt = (state == BUS_ARB_STATE_ARB && m_as_ == DISABLE_ && req_n[owner] == DISABLE_ && pick_vld)
      ? pick : owner;
  end
  always_comb begin
    m_rdy_ = fire ? ENABLE_ : s_rdy_;
    {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt;
  end
`ifdef BUS_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] cnt;
  assign fire = state == BUS_ARB_STATE_BUSY && s_rdy_ == DISABLE_ && cnt == TO_CNT_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      bus_err   <= 1'b0;
      err_owner <= '0;
    end else begin
      cnt     <= state == BUS_ARB_STATE_BUSY ? cnt + TO_CNT_W'(s_rdy_) : '0;
      bus_err <= fire | (bus_err & ~err_clr);
      if (fire) err_owner <= owner;
    end
  end
`else
  logic unused_cfg;
  assign fire       = 1'b0;
  assign bus_err    = 1'b0;
  assign err_owner  = '0;
  assign unused_cfg = err_clr ^ (TIMEOUT_CYC > 0) ^ (TO_CNT_W > 0);
`endif
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: scoreboard bench for bus_rr_arbiter, TIMEOUT_CYC=4, either BUS_ARB_TIMEOUT_EN build
module tb_bus_rr_arbiter;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic m0_req_ = 1'b1, m1_req_ = 1'b1, m2_req_ = 1'b1, m3_req_ = 1'b1;
  logic m_as_ = 1'b1, s_rdy_ = 1'b1, err_clr = 1'b0;
  logic m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, m_rdy_, bus_err;
  logic [1:0] err_owner;
  bus_rr_arbiter #(.TIMEOUT_CYC(4), .TO_CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req_(m0_req_), .m1_req_(m1_req_), .m2_req_(m2_req_), .m3_req_(m3_req_),
    .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
    .m_as_(m_as_), .s_rdy_(s_rdy_), .m_rdy_(m_rdy_),
    .bus_err(bus_err), .err_owner(err_owner), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] grnt;
    logic       mrdy;
    logic       err;
    logic [1:0] eo;
  } exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;
  logic err_m = 1'b0;
  logic [1:0] eo_m = 2'd0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ex(string n, logic [3:0] g, logic r);
    exp_t e;
    e.cyc = cyc; e.name = n; e.grnt = g; e.mrdy = r; e.err = err_m; e.eo = eo_m;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    exp_t x;
    logic [3:0] g;
    g = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      x = q.pop_front();
      checks++;
      if (x.cyc != cyc || g !== x.grnt || m_rdy_ !== x.mrdy || bus_err !== x.err || err_owner !== x.eo) begin
        errors++;
        $display("FAIL %s cyc=%0d: got grnt=%b m_rdy_=%b bus_err=%b err_owner=%0d, expected grnt=%b m_rdy_=%b bus_err=%b err_owner=%0d (cyc %0d)",
                 x.name, cyc, g, m_rdy_, bus_err, err_owner, x.grnt, x.mrdy, x.err, x.eo, x.cyc);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick(); tick();
    ex("reset_state", 4'b1110, 1'b1);
    tick(); reset = 1'b0; ex("idle_park", 4'b1110, 1'b1);
    tick(); s_rdy_ = 1'b0; ex("rdy_follow0", 4'b1110, 1'b0);
    tick(); s_rdy_ = 1'b1; ex("rdy_follow1", 4'b1110, 1'b1);
    repeat (3) tick();
    ex("park_hold", 4'b1110, 1'b1);
    tick(); m0_req_ = 1'b0; m2_req_ = 1'b0; m3_req_ = 1'b0; ex("own0_hold", 4'b1110, 1'b1);
    tick(); ex("own0_hold2", 4'b1110, 1'b1);
    tick(); m0_req_ = 1'b1; ex("m0_release", 4'b1110, 1'b1);
    tick(); ex("grant_m2", 4'b1011, 1'b1);
    tick(); m2_req_ = 1'b1; ex("m2_release", 4'b1011, 1'b1);
    tick(); ex("grant_m3", 4'b0111, 1'b1);
    tick(); m1_req_ = 1'b0; m3_req_ = 1'b1; ex("m3_release", 4'b0111, 1'b1);
    tick(); ex("grant_m1", 4'b1101, 1'b1);
    tick(); m_as_ = 1'b0; ex("busy_strobe", 4'b1101, 1'b1);
    tick(); m_as_ = 1'b1; ex("busy_wait", 4'b1101, 1'b1);
    tick(); m1_req_ = 1'b1; m0_req_ = 1'b0; ex("busy_release", 4'b1101, 1'b1);
    tick(); s_rdy_ = 1'b0; ex("busy_done", 4'b1101, 1'b0);
    tick(); s_rdy_ = 1'b1; ex("arb_after_busy", 4'b1101, 1'b1);
    tick(); ex("grant_m0", 4'b1110, 1'b1);
    tick(); m0_req_ = 1'b1; m3_req_ = 1'b0; ex("m0_release2", 4'b1110, 1'b1);
    tick(); ex("grant_m3b", 4'b0111, 1'b1);
    tick(); m_as_ = 1'b0; ex("to_strobe", 4'b0111, 1'b1);
    tick(); m_as_ = 1'b1; ex("to_wait1", 4'b0111, 1'b1);
    tick(); ex("to_wait2", 4'b0111, 1'b1);
    tick(); ex("to_wait3", 4'b0111, 1'b1);
    tick(); ex("to_fire", 4'b0111, !TO_EN);
    tick();
    if (TO_EN) begin err_m = 1'b1; eo_m = 2'd3; end
    m3_req_ = 1'b1; m0_req_ = 1'b0;
    ex("to_err", 4'b0111, 1'b1);
    tick(); ex("to_after", TO_EN ? 4'b1110 : 4'b0111, 1'b1);
    tick(); s_rdy_ = 1'b0; ex("to_rdy", TO_EN ? 4'b1110 : 4'b0111, 1'b0);
    tick(); s_rdy_ = 1'b1; err_clr = 1'b1; ex("clr_cycle", TO_EN ? 4'b1110 : 4'b0111, 1'b1);
    tick(); err_clr = 1'b0; err_m = 1'b0; ex("cleared", 4'b1110, 1'b1);
    tick(); m_as_ = 1'b0; ex("race_strobe", 4'b1110, 1'b1);
    tick(); m_as_ = 1'b1; ex("race_wait1", 4'b1110, 1'b1);
    tick(); tick(); ex("race_wait3", 4'b1110, 1'b1);
    tick(); s_rdy_ = 1'b0; ex("race_rdy", 4'b1110, 1'b0);
    tick(); s_rdy_ = 1'b1; m0_req_ = 1'b1; m2_req_ = 1'b0; ex("race_noerr", 4'b1110, 1'b1);
    tick(); m_as_ = 1'b0; ex("rst_strobe", 4'b1011, 1'b1);
    tick(); m_as_ = 1'b1; ex("rst_busy", 4'b1011, 1'b1);
    tick(); reset = 1'b1; ex("rst_assert", 4'b1011, 1'b1);
    tick(); reset = 1'b0; eo_m = 2'd0; ex("rst_grant0", 4'b1110, 1'b1);
    tick(); ex("post_rst_m2", 4'b1011, 1'b1);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin bus arbiter for the shared four-master processor bus. It grants ownership of the single master-side bus to one of four requesters and holds ownership stable while a transfer is outstanding. It sits between the bus masters and the address/slave decode path, and monitors the ready returned from the slave multiplexer. An optional watchdog terminates transfers whose slave never answers and latches an error.

## Interface
Parameters:
- TIMEOUT_CYC, 255: cycles without ready, after address strobe, before the watchdog fires; range 1–255.
- TO_CNT_W, 8: watchdog counter width.

Ports:
- clk  in  1  system clock; the block has one clock, and reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- m0_req_ … m3_req_  in  1 each  bus request from masters 0–3, active-low.
- m0_grnt_ … m3_grnt_  out  1 each  registered grant, active-low, exactly one asserted (one-hot low).
- m_as_  in  1  address strobe of the granted master, active-low.
- s_rdy_  in  1  ready from the slave multiplexer, active-low.
- m_rdy_  out  1  ready delivered to masters, active-low.
- bus_err  out  1  sticky timeout error flag.
- err_owner  out  2  master that owned the bus at the last timeout.
- err_clr  in  1  one-cycle pulse that clears bus_err.

## Operation
- Reset values: owner=0, m0_grnt_=0, m1..m3_grnt_=1, state ARB, counter=0, bus_err=0, err_owner=0. m_rdy_ follows s_rdy_ combinationally.
- The bus is parked on the current owner when nobody requests; the bus is never ungranted.
- ARB state:
  - If m_as_=0 and s_rdy_=0 in the same cycle, a zero-wait transfer completes; stay in ARB.
  - If m_as_=0 and s_rdy_=1, go to BUSY and set counter=0.
  - Otherwise, if the owner's req_=1, pick the next owner round-robin. Search from owner+1 upward, wrapping 3→0, and take the first asserted req_. If none is asserted, keep the current owner.
  - An owner with continuous req_=0 keeps the bus indefinitely; there is no fairness preemption.
- BUSY state:
  - Owner and grants are frozen.
  - Return to ARB on s_rdy_=0.
  - Owner release (req_=1) during BUSY is honoured only after returning to ARB.
- Watchdog (when compiled in):
  - In BUSY with s_rdy_=1, the counter increments.
  - When the counter equals TIMEOUT_CYC-1 and s_rdy_=1, the watchdog fires. It drives m_rdy_=0 for that one cycle, sets bus_err=1, captures err_owner=owner, and moves to ARB.
  - If a genuine s_rdy_=0 arrives in the same cycle, it wins: no error is raised.
- err_clr clears bus_err. If a new timeout occurs in the same cycle as err_clr, the set wins. err_owner keeps its last value.
- A reset asserted in BUSY abandons the transfer: owner returns to 0, the counter clears and the flags clear.

## Timing
- Grants are registered. A new owner's grant asserts in the cycle after the ARB cycle in which the old owner's req_=1 was sampled. The old grant deasserts in the same edge, so there is no overlap and no gap.
- Minimum handover latency is 1 cycle. For four continuously requesting masters releasing in turn, the order is 0→1→2→3→0.
- The timeout pulse occurs exactly TIMEOUT_CYC cycles after the m_as_ cycle, with bus_err visible on the following edge.
- m_rdy_ has zero latency from s_rdy_ (combinational gating only).

## Configuration
- Macro BUS_ARB_TIMEOUT_EN.
  - Defined: the watchdog counter, forced ready, bus_err and err_owner logic are present as described.
  - Undefined: no counter. m_rdy_ = s_rdy_, bus_err tied 0, err_owner tied 0, err_clr ignored. BUSY exits only on s_rdy_=0.
- Ports are identical in both builds.

## Structure
- Shared bus header:
  - Owner width constant BusOwnerBus (2 bits).
  - Owner codes BUS_OWNER_MASTER_0..3.
  - Arbiter state codes BUS_ARB_STATE_ARB and BUS_ARB_STATE_BUSY.
  - Existing ENABLE_/DISABLE_ polarity constants.
- One sub-module, bus_rr_pick: a combinational round-robin picker. Inputs are the current owner and a 4-bit request vector; outputs are the next owner and a valid bit. It is instantiated once.

## Test plan
- Reset, then all req_=1: m0_grnt_=0 and the others stay 1 indefinitely; m_rdy_ tracks s_rdy_.
- Owner 0 holds the bus while m2_req_ and m3_req_ are 0. Owner 0 releases at cycle N: at N+1 m2_grnt_=0 and m0_grnt_=1. Owner 2 then releases: m3_grnt_=0 one cycle later.
- Owner 1 issues m_as_=0 with s_rdy_ held 1 for 5 cycles and releases req_ at cycle 2 while m0_req_=0. Grant stays on 1 until s_rdy_=0; m0_grnt_=0 on the next cycle.
- With TIMEOUT_CYC=4, owner 3 issues m_as_ and s_rdy_ is never returned. m_rdy_=0 for exactly one cycle, 4 cycles after the strobe; bus_err=1 and err_owner=3. An err_clr pulse then gives bus_err=0.
- With TIMEOUT_CYC=4, s_rdy_=0 arrives exactly on the firing cycle: bus_err stays 0. Reset asserted during BUSY: grants return to master 0 at the next edge.
- Build without BUS_ARB_TIMEOUT_EN and repeat the timeout stimulus: m_rdy_ stays 1, bus_err=0, and the grant stays frozen until s_rdy_=0.
